// File: rtl/vga_timing_pkg.sv
// Mode constants for the VGA raster timing generator, plus a helper that sums
// one axis's timing (active + front porch + sync + back porch) into its total.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_H_POL    = 1'b0;
  localparam bit VGA640_V_POL    = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_H_POL    = 1'b1;
  localparam bit SVGA800_V_POL    = 1'b1;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Clock-enable-gated shift register, DEPTH stages of WIDTH bits each.
// Every stage clears to RESET_VAL on reset, so a flushed pipeline reads as idle.
module vga_sync_delay #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else if (ce) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, frame counter,
// and sync/blank outputs delayed to line up with the renderer pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FP       = VGA640_H_FP,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BP       = VGA640_H_BP,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FP       = VGA640_V_FP,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BP       = VGA640_V_BP,
  parameter bit H_POL      = VGA640_H_POL,
  parameter bit V_POL      = VGA640_V_POL,
  parameter int CNT_W      = 10,
  parameter int SYNC_DELAY = 1,
  parameter int FRAME_W    = 16
) (
  input  logic               VGA_clk,
  input  logic               reset,
  input  logic               ce,
  output logic [CNT_W-1:0]   xPixel,
  output logic [CNT_W-1:0]   yPixel,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               display_area,
  output logic               blank_n,
  output logic               VGA_hSync,
  output logic               VGA_vSync
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (SYNC_DELAY < 1 || SYNC_DELAY > 8) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY must be within 1..8");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
      $error("vga_timing_gen: timing parameters must be non-zero");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  // One extra bit on every bound so porch/sync sums cannot wrap at CNT_W.
  localparam logic [CNT_W:0] H_LAST   = (CNT_W+1)'(H_TOTAL - 1);
  localparam logic [CNT_W:0] V_LAST   = (CNT_W+1)'(V_TOTAL - 1);
  localparam logic [CNT_W:0] H_ACT    = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] V_ACT    = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] HS_BEGIN = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_BEGIN = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W:0] x_ext;
  logic [CNT_W:0] y_ext;
  logic           x_last;
  logic           y_last;

  assign x_ext  = {1'b0, xPixel};
  assign y_ext  = {1'b0, yPixel};
  assign x_last = (x_ext == H_LAST);
  assign y_last = (y_ext == V_LAST);

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      xPixel      <= '0;
      yPixel      <= '0;
      frame_count <= '0;
    end else if (ce) begin
      if (x_last) begin
        xPixel <= '0;
        if (y_last) begin
          yPixel      <= '0;
          frame_count <= frame_count + 1'b1;
        end else begin
          yPixel <= yPixel + 1'b1;
        end
      end else begin
        xPixel <= xPixel + 1'b1;
      end
    end
  end

  assign line_start  = (xPixel == '0);
  assign frame_start = (xPixel == '0) && (yPixel == '0);

  logic       act;
  logic       hs;
  logic       vs;
  logic [2:0] delayed;

  assign act = (x_ext < H_ACT) && (y_ext < V_ACT);
  assign hs  = (x_ext >= HS_BEGIN) && (x_ext < HS_END);
  assign vs  = (y_ext >= VS_BEGIN) && (y_ext < VS_END);

  // Pipeline carries active-high raw flags; polarity is applied only at the pins
  // so a cleared stage always reads as "sync inactive, blanked".
  vga_sync_delay #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (3'b000)
  ) u_sync_delay (
    .clk  (VGA_clk),
    .rst  (reset),
    .ce   (ce),
    .din  ({act, hs, vs}),
    .dout (delayed)
  );

  assign display_area = delayed[2];
  assign blank_n      = delayed[2];
  assign VGA_hSync    = delayed[1] ^ ~H_POL;
  assign VGA_vSync    = delayed[0] ^ ~V_POL;

endmodule
